// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sync generator / recoverer pair.
// Holds the recoverer state encoding and the tick-counter width helper
// so that both sides size their porch/sync counters identically.
package vga_pkg;

  // Recoverer states: searching for a sync edge, then tracking each region.
  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    SYNC   = 3'd1,
    BACK   = 3'd2,
    ACTIVE = 3'd3,
    FRONT  = 3'd4
  } vga_state_t;

  // Width of a counter able to hold the longest of the four region lengths.
  function automatic int tick_width(input int fp, input int sl, input int bp, input int al);
    int m;
    m = fp;
    if (sl > m) m = sl;
    if (bp > m) m = bp;
    if (al > m) m = al;
    if (m < 1) return 1;
    else return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/vga_sync_recover.sv
// vga_sync_recover: measures a single sync line against the programmed
// front porch / sync / back porch / active lengths, locks after a run of
// good periods and regenerates active, cycle and the active-position counter.
// Optional: define VGA_SYNC_RECOVER_ERRCNT_EN to add an 8-bit saturating
// err_count output (cleared only by rst_n).
module vga_sync_recover
  import vga_pkg::*;
#(
  parameter int frontporch_len = 3,
  parameter int sync_len       = 2,
  parameter int backporch_len  = 1,
  parameter int active_len     = 4,
  parameter int lock_periods   = 2,
  parameter bit sync_polarity  = 1'b1,
  localparam int cnt_w  = (active_len > 1) ? $clog2(active_len) : 1,
  localparam int tc_w   = tick_width(frontporch_len, sync_len, backporch_len, active_len),
  localparam int lock_w = (lock_periods > 0) ? $clog2(lock_periods + 1) : 1
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sync_in,
  output logic             active,
  output logic             cycle,
  output logic [cnt_w-1:0] counter,
  output logic             locked,
  output logic             err
`ifdef VGA_SYNC_RECOVER_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam logic [tc_w-1:0]   sync_tc  = tc_w'(sync_len);
  localparam logic [tc_w-1:0]   back_tc  = tc_w'(backporch_len);
  localparam logic [tc_w-1:0]   front_tc = tc_w'(frontporch_len);
  localparam logic [tc_w-1:0]   one_tc   = tc_w'(1);
  localparam logic [cnt_w-1:0]  last_cnt = cnt_w'(active_len - 1);
  localparam logic [lock_w-1:0] lock_max = lock_w'(lock_periods);

  vga_state_t        state_r, state_s;
  logic [tc_w-1:0]   tc_r, tc_s;
  logic [cnt_w-1:0]  cnt_r, cnt_s;
  logic [lock_w-1:0] good_r, good_s;
  logic              sync_s;
  logic              err_s;
  logic              good_period_s;
  logic              locked_s;
  logic              active_s;
  logic              cycle_s;

  // Next-state decode: one step of the timing FSM per enable tick.
  always_comb begin
    sync_s        = (sync_in == sync_polarity);
    state_s       = state_r;
    tc_s          = tc_r;
    cnt_s         = cnt_r;
    err_s         = 1'b0;
    good_period_s = 1'b0;
    case (state_r)
      HUNT: begin
        if (sync_s) begin
          state_s = SYNC;
          tc_s    = one_tc;
        end else begin
          state_s = HUNT;
        end
      end
      SYNC: begin
        if (sync_s) begin
          if (tc_r == sync_tc) begin
            err_s   = 1'b1;   // sync held too long
            state_s = HUNT;
          end else begin
            tc_s = tc_r + one_tc;
          end
        end else begin
          if (tc_r == sync_tc) begin
            state_s = BACK;
            tc_s    = one_tc;
          end else begin
            err_s   = 1'b1;   // sync too short
            state_s = HUNT;
          end
        end
      end
      BACK: begin
        if (sync_s) begin
          err_s   = 1'b1;     // treat as a fresh sync edge
          state_s = SYNC;
          tc_s    = one_tc;
        end else if (tc_r == back_tc) begin
          state_s = ACTIVE;
          cnt_s   = '0;
        end else begin
          tc_s = tc_r + one_tc;
        end
      end
      ACTIVE: begin
        if (sync_s) begin
          err_s   = 1'b1;
          state_s = SYNC;
          tc_s    = one_tc;
        end else if (cnt_r == last_cnt) begin
          state_s = FRONT;
          tc_s    = one_tc;
        end else begin
          cnt_s = cnt_r + cnt_w'(1);
        end
      end
      FRONT: begin
        // tc counts porch ticks already seen; the entry tick is porch tick 1,
        // so the expected sync lands on porch tick frontporch_len+1, i.e.
        // while tc == frontporch_len.
        if (sync_s) begin
          state_s = SYNC;
          tc_s    = one_tc;
          if (tc_r == front_tc) begin
            good_period_s = 1'b1;
          end else begin
            err_s = 1'b1;     // early sync
          end
        end else if (tc_r == front_tc) begin
          err_s   = 1'b1;     // late sync
          state_s = HUNT;
        end else begin
          tc_s = tc_r + one_tc;
        end
      end
      default: begin
        state_s = HUNT;
        tc_s    = '0;
        cnt_s   = '0;
      end
    endcase

    if (err_s) begin
      good_s = '0;
    end else if (good_period_s && (good_r != lock_max)) begin
      good_s = good_r + lock_w'(1);
    end else begin
      good_s = good_r;
    end

    locked_s = !err_s && (good_s == lock_max);
    active_s = locked_s && (state_s == ACTIVE);
    cycle_s  = active_s && (cnt_s == last_cnt);
  end

  // State and registered outputs, advancing only on enable ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HUNT;
      tc_r    <= '0;
      cnt_r   <= '0;
      good_r  <= '0;
      active  <= 1'b0;
      cycle   <= 1'b0;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else if (enable) begin
      state_r <= state_s;
      tc_r    <= tc_s;
      cnt_r   <= cnt_s;
      good_r  <= good_s;
      active  <= active_s;
      cycle   <= cycle_s;
      locked  <= locked_s;
      err     <= err_s;
    end
  end

  assign counter = cnt_r;

`ifdef VGA_SYNC_RECOVER_ERRCNT_EN
  // Saturating tally of error pulses, kept across soft errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (enable && err_s && (err_count != 8'd255)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_recover.sv
// Directed bench for vga_sync_recover with default parameters.
// Generator phase p (0..9): sync 0-1, back porch 2, active 3-6, front 7-9.
// Recovered outputs after the edge of tick t reflect the generator phase of t.
module tb_vga_sync_recover;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       sync_in;
  logic       active;
  logic       cycle;
  logic [1:0] counter;
  logic       locked;
  logic       err;
`ifdef VGA_SYNC_RECOVER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int vectors;
  int miscompares;

  vga_sync_recover dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .sync_in (sync_in),
    .active  (active),
    .cycle   (cycle),
    .counter (counter),
    .locked  (locked),
    .err     (err)
`ifdef VGA_SYNC_RECOVER_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given enable/sync, then check all outputs against
  // the generator phase p and the expected err/lock status.
  task automatic step(input logic en, input logic s, input int p,
                      input logic e_err, input logic e_lock);
    logic e_act;
    enable  = en;
    sync_in = s;
    @(posedge clk);
    #1;
    e_act = e_lock && (p >= 3) && (p <= 6);
    check("err",    {7'd0, err},    {7'd0, e_err});
    check("locked", {7'd0, locked}, {7'd0, e_lock});
    check("active", {7'd0, active}, {7'd0, e_act});
    check("cycle",  {7'd0, cycle},  {7'd0, (e_act && (p == 6))});
    if (e_act) check("counter", {6'd0, counter}, 8'(p - 3));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_active"},  {7'd0, active},  8'd0);
    check({tag, "_cycle"},   {7'd0, cycle},   8'd0);
    check({tag, "_counter"}, {6'd0, counter}, 8'd0);
    check({tag, "_locked"},  {7'd0, locked},  8'd0);
    check({tag, "_err"},     {7'd0, err},     8'd0);
  endtask

  initial begin
    int p;
    logic s;
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    enable  = 1'b0;
    sync_in = 1'b0;

    // Reset state
    #12;
    check_zero("reset");
`ifdef VGA_SYNC_RECOVER_ERRCNT_EN
    check("reset_err_count", err_count, 8'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Clean stream: lock after the sync completing the 2nd good period (t=20)
    for (int t = 0; t < 50; t++) begin
      p = t % 10;
      step(1'b1, (p < 2), p, 1'b0, (t >= 20));
    end

    // Enable 1 clock in 4; garbage sync on idle clocks must be ignored
    for (int t = 50; t < 90; t++) begin
      p = t % 10;
      s = (p < 2);
      step(1'b1, s, p, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, ~s, p, 1'b0, 1'b1);
    end

    // Sync width 3 while locked: err on 3rd high tick, relock by t=120
    for (int t = 90; t < 140; t++) begin
      p = t % 10;
      step(1'b1, (p < 2) || (t == 92), p, (t == 92), (t < 92) || (t >= 120));
    end

    // Early sync on front porch tick 2 (9-tick period), new period from t=149
    for (int t = 140; t < 195; t++) begin
      if (t < 149) p = t - 140;
      else p = (t - 149) % 10;
      step(1'b1, (p < 2), p, (t == 149), (t < 149) || (t >= 169));
    end

    // Asynchronous reset mid-ACTIVE (counter is 2 here)
    check("pre_reset_counter", {6'd0, counter}, 8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int u = 0; u < 25; u++) begin
      p = u % 10;
      step(1'b1, (p < 2), p, 1'b0, (u >= 20));
    end

`ifdef VGA_SYNC_RECOVER_ERRCNT_EN
    // Constant sync: an error every 3 ticks, first on entry from ACTIVE
    step(1'b1, 1'b1, 0, 1'b1, 1'b0);
    check("err_count_first", err_count, 8'd1);
    for (int k = 0; k < 900; k++) begin
      enable  = 1'b1;
      sync_in = 1'b1;
      @(posedge clk);
    end
    #1;
    check("err_count_sat", err_count, 8'd255);
    rst_n = 1'b0;
    #1;
    check("err_count_clr", err_count, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
